tcbm_link_ctrl: RTL

Device-side sequencer for the TCBM paddle port. It runs the DAV/ACK four-phase handshake against the host, owns port A direction and the two status lines, and buffers host-to-device bytes in a small FIFO. Local firmware (the SD bridge) exchanges whole bytes through valid/ready interfaces and never touches the handshake pins directly.

---
 rtl/tcbm_link_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/tcbm_link_ctrl.sv
// TCBM paddle-port device sequencer: DAV/ACK four-phase handshake, port A/status drive, RX byte FIFO.
// Optional handshake watchdog enabled by defining TCBM_TIMEOUT_EN.
module tcbm_link_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dav,
    output logic       ack,
    input  logic [7:0] pa_in,
    output logic [7:0] pa_out,
    output logic       pa_oe,
    output logic [1:0] st_out,
    input  logic       tx_mode,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic [1:0] tx_status,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_HOLD,
        S_TX_SETUP,
        S_TX_HOLD,
        S_RECOVER
    } state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(SETUP_CYCLES + 1);
    localparam logic [SW-1:0] SETUP_LOAD = SW'(SETUP_CYCLES - 1);
    localparam logic [AW:0]   FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SYNC_STAGES < 2 ||
        SETUP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("tcbm_link_ctrl: illegal parameter set");
    end

    state_t          state, state_next;
    logic            dav_s;
    logic [SYNC_STAGES-1:0] sync;
    logic [SW-1:0]   setup_cnt;
    logic            push, pop, full, wd_expired;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;

    // dav is asynchronous to clock; only the last stage is ever observed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], dav};
    end
    assign dav_s = sync[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic; tx_mode only matters while idle.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            S_IDLE: begin
                if (dav_s && !tx_mode && !full)       state_next = S_RX_HOLD;
                else if (dav_s && tx_mode && tx_valid) state_next = S_TX_SETUP;
            end
            S_RX_HOLD: begin
                if (wd_expired)  state_next = S_RECOVER;
                else if (!dav_s) state_next = S_IDLE;
            end
            S_TX_SETUP: begin
                if (wd_expired)             state_next = S_RECOVER;
                else if (setup_cnt == '0)   state_next = S_TX_HOLD;
            end
            S_TX_HOLD: begin
                if (wd_expired)  state_next = S_RECOVER;
                else if (!dav_s) state_next = S_IDLE;
            end
            S_RECOVER: begin
                if (!dav_s) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic: ack and pa_oe decode straight from state so reset drops them at once.
    always_comb begin
        ack      = (state == S_RX_HOLD) || (state == S_TX_HOLD);
        pa_oe    = (state == S_TX_SETUP) || (state == S_TX_HOLD);
        push     = (state == S_IDLE) && dav_s && !tx_mode && !full;
        tx_ready = (state == S_IDLE) && dav_s && tx_mode && tx_valid;
        timeout  = wd_expired;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            setup_cnt <= '0;
            pa_out    <= 8'h00;
            st_out    <= 2'b00;
        end else if (tx_ready) begin
            setup_cnt <= SETUP_LOAD;
            pa_out    <= tx_data;
            st_out    <= tx_status;
        end else if (state == S_TX_SETUP && setup_cnt != '0) begin
            setup_cnt <= setup_cnt - 1'b1;
        end
    end

`ifdef TCBM_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wd;
    logic          hs_state;

    assign hs_state   = (state == S_RX_HOLD) || (state == S_TX_SETUP) || (state == S_TX_HOLD);
    assign wd_expired = hs_state && (wd == WD_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                     wd <= '0;
        else if (state_next != state)  wd <= '0;
        else if (hs_state)             wd <= wd + 1'b1;
    end
`else
    assign wd_expired = 1'b0;
`endif

    // Receive FIFO; a push only happens when not full, so push+pop never overflows.
    assign full     = (count == FIFO_FULL);
    assign rx_valid = (count != '0);
    assign pop      = rx_ready && rx_valid;
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

    // NOTE: storage is not reset; rx_data is masked while empty, so stale entries never show.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= pa_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
